// File: rtl/mealy_seq_pkg.sv
// Shared constants and elaboration-time helpers for the Mealy sequence detector.
// Pattern bit [width-1] is the first bit of the sequence on the wire.
package mealy_seq_pkg;

   localparam int MAX_PATTERN_W = 16;
   localparam int MAX_CHANNELS  = 16;

   typedef logic [MAX_PATTERN_W-1:0] pattern_t;

   // Longest proper prefix of the pattern that is also a suffix of it.
   function automatic int border_len(pattern_t pattern, int width);
      logic ok;
      for (int k = width - 1; k >= 1; k--) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            if (pattern[width-1-i] != pattern[k-1-i]) ok = 1'b0;
         end
         if (ok) return k;
      end
      return 0;
   endfunction

   // Longest suffix of (prefix of length s, then b) that is a prefix of the pattern.
   function automatic int next_len(pattern_t pattern, int width, int s, logic b);
      logic [MAX_PATTERN_W:0] seq;
      logic                   ok;
      seq = '0;
      for (int j = 0; j < s; j++) seq[j] = pattern[width-1-j];
      seq[s] = b;
      for (int t = s + 1; t >= 1; t--) begin
         if (t <= width) begin
            ok = 1'b1;
            for (int i = 0; i < t; i++) begin
               if (seq[s+1-t+i] != pattern[width-1-i]) ok = 1'b0;
            end
            if (ok) return t;
         end
      end
      return 0;
   endfunction

endpackage

// File: rtl/mealy_seq_channel.sv
// One detector channel: prefix-length state register, Mealy match output and,
// when MEALY_SEQ_COUNT_EN is defined, a saturating match counter.
module mealy_seq_channel
   import mealy_seq_pkg::*;
#(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter int                   COUNT_W   = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         ain,
   input  logic                         ain_valid,
   input  logic                         overlap,
`ifdef MEALY_SEQ_COUNT_EN
   input  logic                         count_clr,
   output logic [COUNT_W-1:0]           count,
`endif
   output logic                         aout,
   output logic [$clog2(PATTERN_W)-1:0] state
);

   localparam int SW    = $clog2(PATTERN_W);
   localparam int LW    = $clog2(PATTERN_W + 1);
   localparam int DEPTH = 1 << SW;

   localparam logic [LW-1:0] MATCH_LEN = LW'(PATTERN_W);
   localparam logic [SW-1:0] BORDER    = SW'(border_len(pattern_t'(PATTERN), PATTERN_W));

   if (COUNT_W < 1) begin : g_bad_count_w
      $error("mealy_seq_channel: COUNT_W must be at least 1");
   end

   // Rows beyond PATTERN_W-1 are unreachable and tied off.
   logic [LW-1:0] next_tab [DEPTH][2];

   for (genvar s = 0; s < DEPTH; s++) begin : g_row
      for (genvar b = 0; b < 2; b++) begin : g_bit
         if (s < PATTERN_W) begin : g_live
            assign next_tab[s][b] = LW'(next_len(pattern_t'(PATTERN), PATTERN_W, s, 1'(b)));
         end else begin : g_dead
            assign next_tab[s][b] = '0;
         end
      end
   end

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic [LW-1:0] t;
   logic          match;

   always_comb begin
      t       = next_tab[state_q][ain];
      match   = 1'b0;
      state_d = state_q;
      if (ain_valid) begin
         if (t == MATCH_LEN) begin
            match   = !reset;
            state_d = overlap ? BORDER : '0;
         end else begin
            state_d = t[SW-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= '0;
      else       state_q <= state_d;
   end

   assign aout  = match;
   assign state = state_q;

`ifdef MEALY_SEQ_COUNT_EN
   logic [COUNT_W-1:0] count_q;

   // Clear dominates a coincident match.
   always_ff @(posedge clock) begin
      if (reset || count_clr)         count_q <= '0;
      else if (match && count_q != '1) count_q <= count_q + 1'b1;
   end

   assign count = count_q;
`endif

endmodule

// File: rtl/mealy_seq_detector.sv
// Multi-channel Mealy sequence detector top: CHANNELS independent detectors.
// Optional per-channel match counters are enabled with MEALY_SEQ_COUNT_EN.
module mealy_seq_detector
   import mealy_seq_pkg::*;
#(
   parameter int                   CHANNELS  = 2,
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter int                   COUNT_W   = 8
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [CHANNELS-1:0]                   ain,
   input  logic [CHANNELS-1:0]                   ain_valid,
   input  logic                                  overlap,
`ifdef MEALY_SEQ_COUNT_EN
   input  logic                                  count_clr,
   output logic [CHANNELS*COUNT_W-1:0]           count,
`endif
   output logic [CHANNELS-1:0]                   aout,
   output logic [CHANNELS*$clog2(PATTERN_W)-1:0] state
);

   localparam int SW = $clog2(PATTERN_W);

   if (PATTERN_W < 2 || PATTERN_W > MAX_PATTERN_W) begin : g_bad_pattern_w
      $error("mealy_seq_detector: PATTERN_W out of range 2..%0d", MAX_PATTERN_W);
   end
   if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("mealy_seq_detector: CHANNELS out of range 1..%0d", MAX_CHANNELS);
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      mealy_seq_channel #(
         .PATTERN_W (PATTERN_W),
         .PATTERN   (PATTERN),
         .COUNT_W   (COUNT_W)
      ) u_channel (
         .clock     (clock),
         .reset     (reset),
         .ain       (ain[c]),
         .ain_valid (ain_valid[c]),
         .overlap   (overlap),
`ifdef MEALY_SEQ_COUNT_EN
         .count_clr (count_clr),
         .count     (count[c*COUNT_W +: COUNT_W]),
`endif
         .aout      (aout[c]),
         .state     (state[c*SW +: SW])
      );
   end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed, table-driven bench for mealy_seq_detector (PATTERN=1011, 2 channels).
// Counter checks are active when MEALY_SEQ_COUNT_EN is defined.
module tb_mealy_seq_detector;

   localparam int CH = 2;
   localparam int PW = 4;
   localparam int CW = 2;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic [1:0] ain       = '0;
   logic [1:0] ain_valid = '0;
   logic       overlap   = 1'b0;
   logic [1:0] aout;
   logic [3:0] state;
`ifdef MEALY_SEQ_COUNT_EN
   logic       count_clr = 1'b0;
   logic [3:0] count;
`endif

   always #5 clock = ~clock;

   mealy_seq_detector #(
      .CHANNELS  (CH),
      .PATTERN_W (PW),
      .PATTERN   (4'b1011),
      .COUNT_W   (CW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ain       (ain),
      .ain_valid (ain_valid),
      .overlap   (overlap),
`ifdef MEALY_SEQ_COUNT_EN
      .count_clr (count_clr),
      .count     (count),
`endif
      .aout      (aout),
      .state     (state)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst;
      logic [1:0] ain;
      logic [1:0] vld;
      logic       ovl;
      logic [1:0] exp_aout;
      logic [3:0] exp_st;   // {ch1, ch0} after the edge
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic rst, logic [1:0] a, logic [1:0] vl, logic ovl,
                              logic [1:0] ea, logic [3:0] es);
      vec_t x;
      x.rst = rst; x.ain = a; x.vld = vl; x.ovl = ovl; x.exp_aout = ea; x.exp_st = es;
      return x;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic apply(vec_t x, int idx);
      @(negedge clock);
      reset     = x.rst;
      ain       = x.ain;
      ain_valid = x.vld;
      overlap   = x.ovl;
`ifdef MEALY_SEQ_COUNT_EN
      count_clr = 1'b0;
`endif
      #1;
      check($sformatf("aout_v%0d", idx), int'(aout), int'(x.exp_aout));
      @(posedge clock);
      #1;
      check($sformatf("state_v%0d", idx), int'(state), int'(x.exp_st));
   endtask

   task automatic run(int lo, int hi);
      for (int i = lo; i <= hi; i++) apply(vecs[i], i);
   endtask

`ifdef MEALY_SEQ_COUNT_EN
   task automatic check_count(string name, int c, int exp);
      check(name, int'(count[c*CW +: CW]), exp);
   endtask

   task automatic drive_bit(logic b, logic clr);
      @(negedge clock);
      reset     = 1'b0;
      ain       = {1'b0, b};
      ain_valid = 2'b01;
      overlap   = 1'b1;
      count_clr = clr;
      @(posedge clock);
      #1;
   endtask
`endif

   initial begin
      // A: reset held with active inputs (0-1)
      vecs.push_back(v(1, 2'b11, 2'b11, 1, 2'b00, 4'b0000));
      vecs.push_back(v(1, 2'b11, 2'b11, 1, 2'b00, 4'b0000));
      // B: overlap, ch0 1011011, ch1 zeros (2-8)
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0001));
      vecs.push_back(v(0, 2'b00, 2'b11, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0011));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b01, 4'b0001));
      vecs.push_back(v(0, 2'b00, 2'b11, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0011));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b01, 4'b0001));
      // C: reset, then non-overlap on the same stream (9-16)
      vecs.push_back(v(1, 2'b00, 2'b00, 0, 2'b00, 4'b0000));
      vecs.push_back(v(0, 2'b01, 2'b11, 0, 2'b00, 4'b0001));
      vecs.push_back(v(0, 2'b00, 2'b11, 0, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b11, 0, 2'b00, 4'b0011));
      vecs.push_back(v(0, 2'b01, 2'b11, 0, 2'b01, 4'b0000));
      vecs.push_back(v(0, 2'b00, 2'b11, 0, 2'b00, 4'b0000));
      vecs.push_back(v(0, 2'b01, 2'b11, 0, 2'b00, 4'b0001));
      vecs.push_back(v(0, 2'b01, 2'b11, 0, 2'b00, 4'b0001));
      // D: reset, ch0 gap of 3 cycles between bits 2 and 3 (17-24)
      vecs.push_back(v(1, 2'b00, 2'b00, 1, 2'b00, 4'b0000));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0001));
      vecs.push_back(v(0, 2'b00, 2'b11, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b10, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b10, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b10, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0011));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b01, 4'b0001));
      // E: 1,0,1 to state 3, reset with ain=1 valid (gated), then 1 (25-29)
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0001));
      vecs.push_back(v(0, 2'b00, 2'b11, 1, 2'b00, 4'b0010));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0011));
      vecs.push_back(v(1, 2'b11, 2'b11, 1, 2'b00, 4'b0000));
      vecs.push_back(v(0, 2'b01, 2'b11, 1, 2'b00, 4'b0001));
      // F: ch1 1011 non-overlap while ch0 idles at state 1 (30-33)
      vecs.push_back(v(0, 2'b10, 2'b10, 0, 2'b00, 4'b0101));
      vecs.push_back(v(0, 2'b00, 2'b10, 0, 2'b00, 4'b1001));
      vecs.push_back(v(0, 2'b10, 2'b10, 0, 2'b00, 4'b1101));
      vecs.push_back(v(0, 2'b10, 2'b10, 0, 2'b10, 4'b0001));

      run(0, 1);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_reset_ch0", 0, 0);
      check_count("count_reset_ch1", 1, 0);
`endif
      run(2, 8);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_overlap_ch0", 0, 2);
      check_count("count_overlap_ch1", 1, 0);
`endif
      run(9, 16);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_nonoverlap_ch0", 0, 1);
`endif
      run(17, 24);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_gap_ch0", 0, 1);
`endif
      run(25, 29);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_midreset_ch0", 0, 0);
`endif
      run(30, 33);
`ifdef MEALY_SEQ_COUNT_EN
      check_count("count_f_ch0", 0, 0);
      check_count("count_f_ch1", 1, 1);

      // Saturation: 5 overlapping matches on ch0, counter is 2 bits
      begin
         logic bits [$];
         int   m;
         bits = '{1'b1, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
         @(negedge clock);
         reset = 1'b1; ain_valid = 2'b00; count_clr = 1'b0;
         @(posedge clock);
         #1;
         m = 0;
         for (int i = 0; i < bits.size(); i++) begin
            drive_bit(bits[i], 1'b0);
            if (i >= 3 && i % 3 == 0) m++;
            check_count($sformatf("count_sat_b%0d", i), 0, (m > 3) ? 3 : m);
         end
      end
      // Clear coincident with a match wins
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b1, 1'b1);
      check_count("count_clr_vs_match", 0, 0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b1, 1'b0);
      check_count("count_after_clr", 0, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
